irq_ctl: RTL

Parametrised N-channel interrupt controller for the CTL/INT boards. It generalises the fixed 8-line expanded interrupt bus (`nirqn[7:0]`) and the single `nirq`/`nirqs` request/acknowledge pair into one block. It synchronises N active-low request lines and latches them per channel in level or edge mode. It masks them, resolves fixed priority, drives the unexpanded `nirq` to the interrupt state machine (ISM), and presents a latched vector once the ISM acknowledges.

---
 rtl/irq_ctl_pkg.sv | 14 +
 rtl/irq_ctl_if.sv | 26 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctl.sv | 100 ++++++++++
 4 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared types and constants for the N-channel interrupt controller.
package irq_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] WSEL_MASK = 2'b00;
    localparam logic [1:0] WSEL_CLR  = 2'b01;
    localparam logic [1:0] WSEL_EN   = 2'b10;

endpackage

// File: rtl/irq_ctl_if.sv
// Request lines, ISM handshake and register write port of irq_ctl.
interface irq_ctl_if #(
    parameter int N  = 8,
    parameter int VW = $clog2(N)
);
    logic [N-1:0]  nirqn;
    logic          nirqs;
    logic          we;
    logic [1:0]    wsel;
    logic [N-1:0]  wdata;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic          nirq;
    logic [VW-1:0] vector;
    logic          vvalid;

    modport master (
        output nirqn, nirqs, we, wsel, wdata,
        input  mask, pending, nirq, vector, vvalid
    );

    modport slave (
        input  nirqn, nirqs, we, wsel, wdata,
        output mask, pending, nirq, vector, vvalid
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int N  = 8,
    parameter int VW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [VW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        // Scan downwards so the last hit, the lowest index, is kept.
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) begin
                idx = VW'(i - 1);
            end
        end
        any = |req;
    end
endmodule

// File: rtl/irq_ctl.sv
// N-channel interrupt controller: sync, level/edge latch, mask, priority,
// nirq/nirqs handshake with the ISM and latched vector.
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int           N    = 8,
    parameter int           VW   = $clog2(N),
    parameter logic [N-1:0] EDGE = '0
) (
    input logic       clk,
    input logic       reset,
    irq_ctl_if.slave  bus
);
    logic [N-1:0]  sync1, sync2, line_prev;
    logic [N-1:0]  pending_q, pending_next, mask_q;
    logic [N-1:0]  req, fall, clr;
    logic          enable_q;
    state_t        state, state_next;
    logic          nirq_q, vvalid_q, ack;
    logic [VW-1:0] vector_q, win_idx;
    logic          win_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '1;
            sync2     <= '1;
            line_prev <= '1;
        end else begin
            sync1     <= bus.nirqn;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall = line_prev & ~sync2;
    assign req  = pending_q & ~mask_q;

    irq_prio_enc #(.N(N), .VW(VW)) u_prio (
        .req (req),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        state_next = state;
        ack        = 1'b0;
        case (state)
            IDLE: if (enable_q && win_any) state_next = REQ;
            REQ: begin
                if (!enable_q || !win_any) begin
                    state_next = IDLE;
                end else if (!bus.nirqs) begin
                    state_next = ACK;
                    ack        = 1'b1;
                end
            end
            ACK: if (bus.nirqs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge latches: a new fall overrides any clear in the same cycle.
    always_comb begin
        clr = '0;
        if (bus.we && bus.wsel == WSEL_CLR) clr = bus.wdata;
        if (ack) clr = clr | (N'(1) << win_idx);
        pending_next = (EDGE & ((pending_q & ~clr) | fall)) | (~EDGE & ~sync2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            mask_q    <= '1;
            enable_q  <= 1'b0;
            nirq_q    <= 1'b1;
            vector_q  <= '0;
            vvalid_q  <= 1'b0;
        end else begin
            state     <= state_next;
            pending_q <= pending_next;
            nirq_q    <= (state_next != REQ);
            vvalid_q  <= (state_next == ACK);
            if (ack) vector_q <= win_idx;
            if (bus.we) begin
                case (bus.wsel)
                    WSEL_MASK: mask_q   <= bus.wdata;
                    WSEL_EN:   enable_q <= bus.wdata[0];
                    default:   ;
                endcase
            end
        end
    end

    assign bus.mask    = mask_q;
    assign bus.pending = pending_q;
    assign bus.nirq    = nirq_q;
    assign bus.vector  = vector_q;
    assign bus.vvalid  = vvalid_q;
endmodule
